// File: rtl/skid_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : skid_fifo_if
// Brief    : Handshake, flush and status bundle for skid_fifo.
// Revision : 1.0
// ============================================================================
interface skid_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic               flush;
  logic               valid_in;
  logic               ready_in;
  logic [WIDTH-1:0]   data_in;
  logic               valid_out;
  logic               ready_out;
  logic [WIDTH-1:0]   data_out;
  logic [c_CNT_W-1:0] count;
  logic               empty;
  logic               almost_full;

  modport master (
    output flush, valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, count, empty, almost_full
  );

  modport slave (
    input  flush, valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, count, empty, almost_full
  );
endinterface
`default_nettype wire

// File: rtl/skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : skid_fifo
// Brief    : DEPTH-entry in-order elastic buffer with flush and optional bypass.
// Revision : 1.0
// ============================================================================
module skid_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int BYPASS    = 0,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic       clk,
  input  logic       reset,
  skid_fifo_if.slave fifo
);
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_AF       = c_CNT_W'(AF_THRESH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_blocked;
  logic               w_has_data;
  logic               w_bypass_en;
  logic               w_valid_out;
  logic               w_ready_in;
  logic               w_push;
  logic               w_pop;
  logic               w_through;
  logic               w_push_st;
  logic               w_pop_st;
  logic [c_CNT_W-1:0] w_count_next;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_IDX) ? '0 : p + c_PTR_ONE;
  endfunction

  assign w_blocked   = reset || fifo.flush;
  assign w_has_data  = (r_count != '0);
  assign w_valid_out = !w_blocked && (w_has_data || (w_bypass_en && fifo.valid_in));
  assign w_pop       = w_valid_out && fifo.ready_out;
  assign w_ready_in  = !w_blocked && ((r_count != c_FULL) || w_pop);
  assign w_push      = fifo.valid_in && w_ready_in;
  // An empty-queue word taken by the consumer this cycle never touches storage.
  assign w_through   = w_bypass_en && !w_has_data && w_push && w_pop;
  assign w_push_st   = w_push && !w_through;
  assign w_pop_st    = w_pop && !w_through;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_st, w_pop_st})
      2'b10:   w_count_next = r_count + c_CNT_ONE;
      2'b01:   w_count_next = r_count - c_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_blocked) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_st) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop_st)  r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_st) r_mem[r_wr_ptr] <= fifo.data_in;
  end

  if (BYPASS != 0) begin : g_bypass
    assign w_bypass_en   = 1'b1;
    assign fifo.data_out = w_has_data ? r_mem[r_rd_ptr] : fifo.data_in;
  end else begin : g_no_bypass
    assign w_bypass_en   = 1'b0;
    assign fifo.data_out = r_mem[r_rd_ptr];
  end

  assign fifo.valid_out   = w_valid_out;
  assign fifo.ready_in    = w_ready_in;
  assign fifo.count       = r_count;
  assign fifo.empty       = !w_has_data;
  assign fifo.almost_full = (r_count >= c_AF);
endmodule
`default_nettype wire

// File: tb/tb_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_fifo
// Brief    : Directed + random bench for skid_fifo against a queue model.
// Revision : 1.0
// ============================================================================
module tb_skid_fifo;
  localparam int W   = 8;
  localparam int DA  = 4;
  localparam int AFA = 3;
  localparam int DB  = 3;
  localparam int AFB = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] a_out[$];
  logic [W-1:0] b_out[$];
  int a_nin = 0, a_nout = 0, b_nin = 0, b_nout = 0;
  int b_max_cnt = 0;

  always #5 clk = ~clk;

  skid_fifo_if #(.WIDTH(W), .DEPTH(DA)) ifa ();
  skid_fifo_if #(.WIDTH(W), .DEPTH(DB)) ifb ();

  skid_fifo #(.WIDTH(W), .DEPTH(DA), .BYPASS(0), .AF_THRESH(AFA)) dut_a (
    .clk(clk), .reset(reset), .fifo(ifa.slave)
  );
  skid_fifo #(.WIDTH(W), .DEPTH(DB), .BYPASS(1), .AF_THRESH(AFB)) dut_b (
    .clk(clk), .reset(reset), .fifo(ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    ifa.valid_in = v; ifa.data_in = d; ifa.ready_out = r; ifa.flush = f;
  endtask

  task automatic drive_b(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    ifb.valid_in = v; ifb.data_in = d; ifb.ready_out = r; ifb.flush = f;
  endtask

  // One clock: check handshake outputs, advance the model, check status.
  task automatic tick();
    logic blka, va, ra, pa, sa, blkb, vb, rb, pb, sb;
    logic [W-1:0] ina, inb, eb;
    #1;
    blka = reset || ifa.flush;
    va   = !blka && (qa.size() != 0);
    pa   = va && ifa.ready_out;
    ra   = !blka && (qa.size() < DA || pa);
    sa   = ifa.valid_in && ra;
    ina  = ifa.data_in;
    chk("a_valid_out", ifa.valid_out, va);
    chk("a_ready_in", ifa.ready_in, ra);
    if (va) chk("a_data_out", ifa.data_out, qa[0]);
    if (ifa.valid_in && ifa.ready_in) a_nin++;
    if (ifa.valid_out && ifa.ready_out) begin a_nout++; a_out.push_back(ifa.data_out); end

    blkb = reset || ifb.flush;
    vb   = !blkb && (qb.size() != 0 || ifb.valid_in);
    pb   = vb && ifb.ready_out;
    rb   = !blkb && (qb.size() < DB || pb);
    sb   = ifb.valid_in && rb;
    inb  = ifb.data_in;
    eb   = (qb.size() != 0) ? qb[0] : ifb.data_in;
    chk("b_valid_out", ifb.valid_out, vb);
    chk("b_ready_in", ifb.ready_in, rb);
    if (vb) chk("b_data_out", ifb.data_out, eb);
    if (ifb.valid_in && ifb.ready_in) b_nin++;
    if (ifb.valid_out && ifb.ready_out) begin b_nout++; b_out.push_back(ifb.data_out); end

    @(posedge clk);
    if (blka) qa.delete();
    else begin
      if (pa) void'(qa.pop_front());
      if (sa) qa.push_back(ina);
    end
    if (blkb) qb.delete();
    else if (!(qb.size() == 0 && sb && pb)) begin
      if (pb) void'(qb.pop_front());
      if (sb) qb.push_back(inb);
    end

    @(negedge clk);
    chk("a_count", ifa.count, qa.size());
    chk("a_empty", ifa.empty, qa.size() == 0);
    chk("a_almost_full", ifa.almost_full, qa.size() >= AFA);
    chk("b_count", ifb.count, qb.size());
    chk("b_empty", ifb.empty, qb.size() == 0);
    chk("b_almost_full", ifb.almost_full, qb.size() >= AFB);
    if (int'(ifb.count) > b_max_cnt) b_max_cnt = int'(ifb.count);
  endtask

  initial begin
    int   n0, n1, sent;
    logic v;

    reset = 1'b1;
    drive_a(0, '0, 0, 0);
    drive_b(0, '0, 0, 0);
    tick(); tick();
    chk("rst_a_empty", ifa.empty, 1);
    chk("rst_a_af", ifa.almost_full, 0);
    chk("rst_a_ready_in", ifa.ready_in, 0);
    reset = 1'b0;
    #1 chk("post_rst_ready_in", ifa.ready_in, 1);
    tick();

    // Fill/drain on the 4-deep, non-bypass instance
    n0 = a_nin;
    for (int i = 0; i < 5; i++) begin
      drive_a(1, W'(8'hA0 + i), 0, 0);
      tick();
      if (i == 1) chk("af_after_2nd", ifa.almost_full, 0);
      if (i == 2) chk("af_after_3rd", ifa.almost_full, 1);
    end
    chk("fill_accepted", a_nin - n0, 4);
    chk("fill_count", ifa.count, 4);
    chk("full_ready_in", ifa.ready_in, 0);
    a_out.delete();
    drive_a(1, 8'hA4, 1, 0);
    tick();
    chk("a4_taken_on_pop", a_nin - n0, 5);
    drive_a(0, '0, 1, 0);
    repeat (4) tick();
    chk("drain_len", a_out.size(), 5);
    for (int i = 0; i < 5 && i < a_out.size(); i++) chk("drain_order", a_out[i], 8'hA0 + i);

    // Full queue, one push and one pop every cycle
    for (int i = 0; i < 4; i++) begin drive_a(1, W'(i), 0, 0); tick(); end
    a_out.delete();
    n0 = a_nin; n1 = a_nout;
    for (int i = 0; i < 20; i++) begin drive_a(1, W'(4 + i), 1, 0); tick(); end
    chk("thru_pushes", a_nin - n0, 20);
    chk("thru_pops", a_nout - n1, 20);
    chk("thru_count", ifa.count, 4);
    for (int i = 0; i < 20 && i < a_out.size(); i++) chk("thru_order", a_out[i], i);
    drive_a(0, '0, 1, 0);
    repeat (4) tick();

    // Flush with 3 entries, producer and consumer both active
    for (int i = 0; i < 3; i++) begin drive_a(1, W'(8'hC0 + i), 0, 0); tick(); end
    drive_a(1, 8'hEE, 1, 1);
    #1 chk("flush_ready_in", ifa.ready_in, 0);
    chk("flush_valid_out", ifa.valid_out, 0);
    tick();
    chk("flush_empty", ifa.empty, 1);
    chk("flush_count", ifa.count, 0);
    drive_a(1, 8'h55, 0, 0);
    #1 chk("post_flush_ready", ifa.ready_in, 1);
    tick();
    a_out.delete();
    drive_a(0, '0, 1, 0);
    tick();
    chk("post_flush_len", a_out.size(), 1);
    if (a_out.size() > 0) chk("post_flush_word", a_out[0], 8'h55);

    // Bypass on the 3-deep instance
    drive_b(0, '0, 0, 1);
    tick();
    drive_b(1, 8'h77, 1, 0);
    #1 chk("byp_valid_out", ifb.valid_out, 1);
    chk("byp_data_out", ifb.data_out, 8'h77);
    tick();
    chk("byp_count", ifb.count, 0);
    drive_b(1, 8'h77, 0, 0);
    tick();
    chk("byp_stall_count", ifb.count, 1);
    drive_b(0, '0, 1, 0);
    tick();

    // Pointer wrap: 10 words through the 3-deep queue under random stalls
    b_out.delete();
    b_max_cnt = 0;
    sent = 0;
    for (int cyc = 0; cyc < 400 && b_out.size() < 10; cyc++) begin
      v = (sent < 10) && ($urandom_range(0, 3) != 0);
      drive_b(v, W'(8'h30 + sent), 1'($urandom_range(0, 1)), 0);
      n0 = b_nin;
      tick();
      if (b_nin != n0) sent++;
    end
    chk("wrap_words_out", b_out.size(), 10);
    for (int i = 0; i < 10 && i < b_out.size(); i++) chk("wrap_order", b_out[i], 8'h30 + i);
    chk("wrap_max_count_ok", b_max_cnt <= DB, 1);

    // Random traffic on both instances, occasional flush
    for (int i = 0; i < 400; i++) begin
      drive_a(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 29) == 0));
      drive_b(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 29) == 0));
      tick();
    end

    // Reset mid-stream with 2 entries held
    drive_a(0, '0, 0, 1);
    drive_b(0, '0, 0, 0);
    tick();
    drive_a(1, 8'h61, 0, 0); tick();
    drive_a(1, 8'h62, 0, 0); tick();
    chk("pre_rst_count", ifa.count, 2);
    reset = 1'b1;
    drive_a(1, 8'h99, 1, 0);
    #1 chk("rst_mid_valid_out", ifa.valid_out, 0);
    chk("rst_mid_ready_in", ifa.ready_in, 0);
    tick();
    reset = 1'b0;
    drive_a(0, '0, 0, 0);
    #1 chk("rst_release_ready", ifa.ready_in, 1);
    tick();
    chk("rst_release_count", ifa.count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/skid_fifo.md
# skid_fifo

Parametrised multi-entry elastic buffer for valid/ready pipeline links in the out-of-order core, e.g. fetch→decode and dispatch→issue. It replaces single-slot skid stages with a DEPTH-entry in-order queue and adds a synchronous flush for mispredict/exception recovery. It also provides optional zero-latency bypass and occupancy status outputs. It sustains 1 transfer/cycle, including when full and draining.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 4, number of storage entries (≥2, any integer, not restricted to powers of two)
- BYPASS, 0, 1 = when empty, input is presented combinationally on output in the same cycle
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- flush  input  1  synchronous discard of all entries this cycle
- valid_in  input  1  producer has data
- ready_in  output  1  block accepts data this cycle
- data_in  input  WIDTH  producer payload
- valid_out  output  1  block presents data
- ready_out  input  1  consumer accepts data
- data_out  output  WIDTH  head-of-queue payload (or bypassed data_in)
- count  output  $clog2(DEPTH+1)  number of stored entries
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_THRESH

## Operation
- Storage: DEPTH×WIDTH array; rd_ptr and wr_ptr of width max(1,$clog2(DEPTH)). Pointers wrap explicitly from DEPTH-1 to 0, never by natural overflow. count is held in a register, not derived from pointers.
- Transfers are defined as push = valid_in && ready_in and pop = valid_out && ready_out.
- valid_out = (count != 0) || (BYPASS && valid_in), forced 0 during reset or flush.
- data_out = mem[rd_ptr] when count != 0; data_in when BYPASS and count == 0.
- ready_in = (count < DEPTH) || pop, forced 0 during reset or flush. When full, a same-cycle pop frees the slot for the push.
- Bypass case (BYPASS=1, count==0, valid_in, ready_out): the word goes straight through. Nothing is written, pointers and count are unchanged.
- Otherwise a push writes mem[wr_ptr] and advances wr_ptr, and a pop advances rd_ptr.
- count_next = count + push_stored − pop_stored. Simultaneous push and pop leave count unchanged and advance both pointers.
- flush has priority over all transfers. count, rd_ptr and wr_ptr go to 0; no push or pop occurs that cycle. Array contents are don't-care.
- reset has priority over flush with identical state effect. The array is not reset.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush.

## Timing
- Reset values: count=0, empty=1, almost_full=0 (AF_THRESH≥1), valid_out=0. ready_in=0 while reset is high and 1 from the first cycle after release.
- Latency: BYPASS=0 gives 1 cycle minimum, data pushed at edge N is visible on data_out in cycle N+1. BYPASS=1 with empty queue gives 0 cycles.
- Throughput is 1 word/cycle in steady state at any occupancy, including full with ready_out=1.
- ready_in depends combinationally on ready_out (and valid_in when BYPASS=1). valid_out depends combinationally on valid_in only when BYPASS=1.
- Boundary conditions:
  - Full with no pop: ready_in=0, and valid_in is held off without data loss.
  - Empty with BYPASS=0: valid_out=0 regardless of valid_in.
  - Flush while full with valid_in=1 and ready_out=1: no transfer occurs. The next cycle has empty=1 and ready_in=1.
  - Reset mid-stream: all entries are discarded identically to flush.
- count, empty and almost_full are registered-state-derived and update on the edge after the causing transfer.

## Test plan
- Fill/drain, DEPTH=4, BYPASS=0: push 0xA0..0xA4 with ready_out=0. Four are accepted, ready_in drops after the 4th, and count=4, almost_full=1 after the 3rd. Releasing ready_out pops A0..A3 in order, one per cycle, then A4.
- Full-throughput: with full queue and valid_in=ready_out=1 for 20 cycles, 20 pushes and 20 pops occur. count stays 4 and order is preserved.
- Pointer wrap with DEPTH=3: stream 10 words with random ready_out stalls. Output order matches input, and count never exceeds 3.
- Flush: with 3 entries, assert flush with valid_in=1 and ready_out=1. ready_in=0 and valid_out=0 that cycle, and the next cycle has count=0, empty=1. The first word pushed afterwards (0x55) is the next output.
- Bypass, BYPASS=1: when empty, valid_in=1, data_in=0x77, ready_out=1 gives data_out=0x77 and valid_out=1 in the same cycle, with count staying 0. With ready_out=0, the word is stored and count=1.
- Reset mid-operation: with 2 entries, assert reset for 1 cycle. valid_out=0 and ready_in=0 during reset, and count=0, ready_in=1 afterwards.
